pipe_stage_reg: RTL

//   Generic, parametrised pipeline-stage register for the pipelined core. It

---
 rtl/pipe_stage_reg.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with ctrl/data bundles,
// optional 2-entry skid buffer and synchronous flush.
//
// Ports:
//   clk, reset_n (sync, active low), flush
//   in_valid/in_ready/in_ctrl/in_data    upstream beat
//   out_valid/out_ready/out_ctrl/out_data downstream beat
//   occupancy  entries held (0..2)
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam bit LP_SKID = (SKID != 0);

  logic              r_main_vld;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_vld;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [1:0]        r_occ;

  logic              w_acc;
  logic              w_cons;
  logic              w_main_free;
  logic              w_skid_to_main;
  logic              w_in_to_main;
  logic              w_in_to_skid;
  logic              w_main_vld_nxt;
  logic [CTRL_W-1:0] w_main_ctrl_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic              w_skid_vld_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [1:0]        w_occ_nxt;

  // Skid mode: ready comes only from the skid flag, so
  // out_ready never reaches in_ready.
  always_comb begin
    if (LP_SKID) begin
      in_ready = reset_n & ~r_skid_vld;
    end else begin
      in_ready = reset_n & (~r_main_vld | out_ready);
    end
  end

  assign w_acc  = in_valid & in_ready;
  assign w_cons = r_main_vld & out_ready;

  always_comb begin
    w_main_free    = ~r_main_vld | w_cons;
    w_skid_to_main = LP_SKID & r_skid_vld & w_main_free;
    w_in_to_main   = w_acc & w_main_free & ~w_skid_to_main;
    // A beat that cannot enter main parks in skid.
    w_in_to_skid   = LP_SKID & w_acc
                   & (~w_main_free | w_skid_to_main);

    w_main_vld_nxt  = w_skid_to_main | w_in_to_main
                    | (r_main_vld & ~w_cons);
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    if (w_skid_to_main) begin
      w_main_ctrl_nxt = r_skid_ctrl;
      w_main_data_nxt = r_skid_data;
    end else if (w_in_to_main) begin
      w_main_ctrl_nxt = in_ctrl;
      w_main_data_nxt = in_data;
    end
    // Bubbles carry ctrl=0 so downstream sees a NOP.
    if (!w_main_vld_nxt) begin
      w_main_ctrl_nxt = '0;
    end

    w_skid_vld_nxt  = w_in_to_skid
                    | (r_skid_vld & ~w_skid_to_main);
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;
    if (w_in_to_skid) begin
      w_skid_ctrl_nxt = in_ctrl;
      w_skid_data_nxt = in_data;
    end
    if (!w_skid_vld_nxt) begin
      w_skid_ctrl_nxt = '0;
    end

    w_occ_nxt = {1'b0, w_main_vld_nxt}
              + {1'b0, w_skid_vld_nxt};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_main_vld  <= 1'b0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_occ       <= 2'd0;
    end else if (flush) begin
      // Data bundles keep their value; only
      // validity and ctrl are killed.
      r_main_vld  <= 1'b0;
      r_main_ctrl <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_ctrl <= '0;
      r_occ       <= 2'd0;
    end else begin
      r_main_vld  <= w_main_vld_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_vld  <= w_skid_vld_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_occ       <= w_occ_nxt;
    end
  end

  assign out_valid = r_main_vld;
  assign out_ctrl  = r_main_vld ? r_main_ctrl : '0;
  assign out_data  = r_main_data;
  assign occupancy = r_occ;

  a_stall_stable: assert property (
    @(posedge clk) disable iff (!reset_n)
    (out_valid & ~out_ready) |=> $stable(out_data)
  );

  a_occ_range: assert property (
    @(posedge clk) disable iff (!reset_n)
    LP_SKID || (occupancy <= 2'd1)
  );

  a_no_acc_full: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(in_valid && in_ready && occupancy == 2'd2)
  );

endmodule
